// File: rtl/onehot_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | onehot_seq_pkg : shared mode encodings for the one-hot decode sequencer    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package onehot_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/onehot_enc.sv
// +----------------------------------------------------------------------------+
// | onehot_enc : combinational binary index to one-hot vector encoder         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module onehot_enc #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_index,
  output logic [2**SEL_W-1:0]   o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**SEL_W; gi++) begin : g_bit
      assign o_onehot[gi] = (i_index == SEL_W'(gi));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/onehot_decode_sequencer.sv
// +----------------------------------------------------------------------------+
// | onehot_decode_sequencer : registered one-hot select driver with a direct  |
// | decode mode and an up/down scan sequencer with programmable limit / rate  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module onehot_decode_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     select,
  input  logic                 load,
  input  logic [SEL_W-1:0]     limit,
  output logic [2**SEL_W-1:0]  out,
  output logic [SEL_W-1:0]     index,
  output logic                 wrap,
  output logic                 active
);

  localparam int                 c_NUM_OUT  = 2**SEL_W;
  localparam int                 c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_CNT_ONE  = c_DIV_W'(1);
  localparam logic [SEL_W-1:0]   c_IDX_ONE  = SEL_W'(1);
  localparam logic [c_NUM_OUT-1:0] c_INACTIVE = {c_NUM_OUT{ACTIVE_LOW}};

  logic [SEL_W-1:0]     r_index;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic                 r_wrap;
  logic                 r_active;
  logic [c_NUM_OUT-1:0] r_out;
  logic [1:0]           r_mode_prev;
  logic                 r_mode_vld;

  logic [SEL_W-1:0]     w_index_nxt;
  logic [c_DIV_W-1:0]   w_cnt_nxt;
  logic                 w_wrap_nxt;
  logic [SEL_W-1:0]     w_clamped;
  logic                 w_mode_chg;
  logic [c_NUM_OUT-1:0] w_onehot;
  logic [c_NUM_OUT-1:0] w_out_nxt;

  always_comb begin
    w_index_nxt = r_index;
    w_cnt_nxt   = '0;
    w_wrap_nxt  = 1'b0;
    w_clamped   = (select > limit) ? limit : select;
    // The mode seen before reset is unknown, so the first edge after reset never counts as a change.
    w_mode_chg  = r_mode_vld && (mode != r_mode_prev);

    if (enable) begin
      case (mode_e'(mode))
        MODE_DECODE: w_index_nxt = select;
        MODE_HOLD: begin
          if (load) w_index_nxt = w_clamped;
        end
        default: begin
          if (load) begin
            w_index_nxt = w_clamped;
          end else if (!w_mode_chg) begin
            if (r_div_cnt == c_DIV_LAST) begin
              if (mode == MODE_SCAN_UP) begin
                if (r_index >= limit) begin
                  w_index_nxt = '0;
                  w_wrap_nxt  = 1'b1;
                end else begin
                  w_index_nxt = r_index + c_IDX_ONE;
                end
              end else begin
                // A limit lowered under a running scan pulls the index back without a wrap.
                if (r_index > limit) begin
                  w_index_nxt = limit;
                end else if (r_index == '0) begin
                  w_index_nxt = limit;
                  w_wrap_nxt  = 1'b1;
                end else begin
                  w_index_nxt = r_index - c_IDX_ONE;
                end
              end
            end else begin
              w_cnt_nxt = r_div_cnt + c_CNT_ONE;
            end
          end
        end
      endcase
    end

    w_out_nxt = enable ? (w_onehot ^ c_INACTIVE) : c_INACTIVE;
  end

  onehot_enc #(
    .SEL_W    (SEL_W)
  ) u_enc (
    .i_index  (w_index_nxt),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index     <= '0;
      r_div_cnt   <= '0;
      r_wrap      <= 1'b0;
      r_active    <= 1'b0;
      r_out       <= c_INACTIVE;
      r_mode_prev <= MODE_DECODE;
      r_mode_vld  <= 1'b0;
    end else begin
      r_index     <= w_index_nxt;
      r_div_cnt   <= w_cnt_nxt;
      r_wrap      <= w_wrap_nxt;
      r_active    <= enable;
      r_out       <= w_out_nxt;
      r_mode_prev <= mode;
      r_mode_vld  <= 1'b1;
    end
  end

  assign out    = r_out;
  assign index  = r_index;
  assign wrap   = r_wrap;
  assign active = r_active;

endmodule

`default_nettype wire

// File: doc/onehot_decode_sequencer.md
Name: onehot_decode_sequencer

Overview:
Parametrised, registered successor to the team's 3-to-8 enable decoder. Drives a one-hot output bus of 2**SEL_W lines from an index. The index is either loaded directly (decode mode) or stepped by an internal scan sequencer (up/down, programmable limit, programmable step rate). Used for row/bank selection and for time-multiplexed strobing of peripheral selects.

Parameters:
SEL_W, 3, index width; output bus width is NUM_OUT = 2**SEL_W (localparam, not overridable)
SCAN_DIV, 4, clock cycles per scan step; legal range >= 1
ACTIVE_LOW, 0, 1 inverts every bit of out (the inactive level becomes 1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  output enable; low forces out inactive
mode  in  2  00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
select  in  SEL_W  direct index (DECODE) or load value (scan modes)
load  in  1  single-cycle pulse; loads select into index in scan/HOLD modes
limit  in  SEL_W  highest index visited by scan
out  out  NUM_OUT  registered one-hot select lines
index  out  SEL_W  registered current index
wrap  out  1  one-cycle pulse when scan wraps
active  out  1  registered copy of enable (out currently valid)

Behaviour:
- Reset (rst_n low, async):
  - index=0, div_cnt=0, wrap=0, active=0.
  - out = all inactive: 0, or all 1s if ACTIVE_LOW.
- All state changes on the rising edge of clk. Latency is 1 cycle from inputs to index/out.
- out is always computed from the next index value, so out and index are consistent in every cycle. No combinational path from inputs to out.
- enable=0:
  - out becomes inactive next cycle; active=0; wrap=0.
  - index is held; div_cnt is cleared.
  - load is ignored.
- enable=1, active=1, out = onehot(index) (inverted if ACTIVE_LOW). Exactly one line is active.
- DECODE mode:
  - index <= select every cycle.
  - load, limit and div_cnt are ignored; div_cnt is held at 0.
- HOLD mode:
  - index is frozen; div_cnt is held at 0.
  - load still loads: index <= min(select, limit).
- SCAN_UP / SCAN_DOWN:
  - div_cnt counts 0..SCAN_DIV-1. A step occurs on the cycle div_cnt==SCAN_DIV-1, and div_cnt then returns to 0.
  - SCAN_DIV=1 gives a step every cycle.
  - Step up: if index>=limit then index<=0 and wrap=1, else index<=index+1.
  - Step down: if index==0 then index<=limit and wrap=1, else index<=index-1. If index>limit (limit was lowered mid-scan), index<=limit with wrap=0.
  - load: index <= min(select, limit), div_cnt <= 0, wrap=0. Load has priority over a coincident step.
- Any change of mode value: div_cnt <= 0 on that edge; no step occurs on that edge.
- limit=0 in scan modes: index stays 0, and wrap pulses on every step.
- wrap is high for exactly one cycle per wrap and is 0 in DECODE/HOLD.
- Reset asserted mid-scan: immediate return to reset values. After release, scanning resumes from index 0 with a full SCAN_DIV interval before the first step.
- Unsigned arithmetic throughout; index never leaves 0..NUM_OUT-1.

Decomposition:
- Package onehot_seq_pkg: mode encodings MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_HOLD (2-bit).
- One natural sub-module: onehot_enc. It is purely combinational, parametrised SEL_W, and maps index to a NUM_OUT one-hot vector. It is instantiated once, on the next-index value, ahead of the out register.
- The divider and index logic stay in the top module.

Test Plan:
- Reset/decode: rst_n low, then SEL_W=3, enable=1, mode=DECODE, select=5 -> one cycle later out=8'b0010_0000, index=5, active=1. Drop enable -> out=0, index holds 5.
- Scan up with wrap: SCAN_DIV=4, limit=5, load select=3, mode=SCAN_UP -> index 3,4,5,0 changes every 4 cycles. wrap is a single-cycle pulse coincident with index 5->0.
- Scan down and clamp: limit=6, load select=7 -> index=6 (clamped). Then SCAN_DOWN steps 6,5,...,0,6 with wrap on 0->6. Lowering limit to 2 while index=5 -> next step index=2, wrap=0.
- Priority/simultaneity: load select=1 on the exact cycle a step is due -> index=1, no wrap, next step SCAN_DIV cycles later. A mode change mid-count restarts the divider.
- Edge parameters: SCAN_DIV=1, limit=0 -> index stays 0 and wrap is high every cycle. ACTIVE_LOW=1, index=2 -> out=8'b1111_1011; disabled -> out=8'hFF.
- Async reset mid-scan: assert rst_n between clock edges with index=4 -> out inactive and index=0 immediately, without waiting for a clock edge. After release, first step occurs SCAN_DIV cycles later.
